// File: rtl/mdu_pkg.sv
// mdu_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - op encodings as presented on the op input
//   - FSM state encodings (constants plus a matching enum for debug views)
//   - iteration count helpers
package mdu_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      CALC = ST_CALC,
      FIX  = ST_FIX,
      DONE = ST_DONE
   } mdu_state_e;

   localparam int unsigned DEFAULT_WIDTH = 32;

   // Index of the last CALC iteration for a given operand width.
   function automatic int unsigned iter_last(input int unsigned width);
      return width - 1;
   endfunction

   localparam int unsigned ITER_LAST = iter_last(DEFAULT_WIDTH);

   // op[1] selects divide, op[0] selects unsigned.
   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step
// One combinational restoring-division step on unsigned magnitudes.
// Ports:
//   rem          in  WIDTH : partial remainder from the previous step
//   dividend_bit in  1     : next dividend bit, MSB first
//   divisor      in  WIDTH : divisor magnitude
//   rem_next     out WIDTH : partial remainder after this step
//   q_bit        out 1     : quotient bit produced by this step
module mdu_div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             dividend_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   logic [WIDTH:0]   partial;
   logic [WIDTH+1:0] diff;

   // Two guard bits: with a zero divisor the remainder is no longer bounded
   // by the divisor, so partial can use all WIDTH+1 bits. The extra bit keeps
   // the borrow test honest, which makes a zero divisor yield all-ones
   // quotient bits and shift the dividend straight into the remainder.
   assign partial  = {rem, dividend_bit};
   assign diff     = {1'b0, partial} - {2'b00, divisor};
   assign q_bit    = ~diff[WIDTH+1];
   assign rem_next = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit
// Radix-2 iterative MULT/MULTU/DIV/DIVU engine feeding the HI/LO pair.
// Fixed latency: WIDTH CALC cycles, one FIX cycle, one DONE cycle.
// Ports:
//   clk        in  1     : clock, rising edge
//   rst        in  1     : synchronous reset, active-high, highest priority
//   ena        in  1     : block enable; 0 freezes state and masks strobes
//   start      in  1     : launch request
//   op         in  2     : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b       in  WIDTH : rs / rt operands, captured on accepted start
//   busy       out 1     : operation in flight
//   done       out 1     : result cycle (registered, held while ena=0)
//   hi_out     out WIDTH : HI write data (registered)
//   lo_out     out WIDTH : LO write data (registered)
//   hi_w, lo_w out 1     : write strobes, done & ena
//   fsm_state  out 2     : current FSM state for observation
//
// Handshake: a start is accepted only in a cycle where ena=1 and busy=0;
// any other start is dropped, never queued. busy is high from the cycle after
// acceptance through the done cycle, and the strobes fire in exactly one
// enabled cycle while done is high.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             hi_w,
   output logic             lo_w,
   output logic [1:0]       fsm_state
);

   localparam int unsigned        CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(iter_last(WIDTH));

   logic [1:0]         state;
   logic [CNT_W-1:0]   cnt;
   logic               is_div;
   logic               sign_a;
   logic               sign_b;
   logic [WIDTH-1:0]   a_abs;
   logic [WIDTH-1:0]   b_abs;
   logic [WIDTH-1:0]   sh;     // multiplier (shifts right) or dividend (shifts left)
   logic [2*WIDTH-1:0] acc;    // product, or {remainder, quotient} for divide

   // Operand magnitudes at launch; 0x80..0 maps to itself and is read unsigned.
   logic               start_signed;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;

   assign start_signed = op_is_signed(op);
   assign a_mag = (start_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
   assign b_mag = (start_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

   // Shift-add multiply step: add the multiplicand into the upper half when
   // the current multiplier bit is set, then shift the whole accumulator right.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (sh[0] ? a_abs : {WIDTH{1'b0}})};
   assign mul_next = {mul_sum, acc[WIDTH-1:1]};

   // Restoring divide step: remainder lives in the upper half, quotient bits
   // shift into the lower half.
   logic [WIDTH-1:0]   div_rem;
   logic               div_q;
   logic [2*WIDTH-1:0] div_next;

   mdu_div_step #(
      .WIDTH(WIDTH)
   ) u_div_step (
      .rem          (acc[2*WIDTH-1:WIDTH]),
      .dividend_bit (sh[WIDTH-1]),
      .divisor      (b_abs),
      .rem_next     (div_rem),
      .q_bit        (div_q)
   );

   assign div_next = {div_rem, acc[WIDTH-2:0], div_q};

   // Sign fix applied in FIX. Unsigned ops never set the sign flags, so the
   // same expressions serve all four ops.
   logic               neg_result;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_raw;
   logic [WIDTH-1:0]   rem_raw;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic               div_zero;

   assign neg_result = sign_a ^ sign_b;
   assign prod_fix   = neg_result ? (~acc + 1'b1) : acc;
   assign quo_raw    = acc[WIDTH-1:0];
   assign rem_raw    = acc[2*WIDTH-1:WIDTH];
   assign div_zero   = (b_abs == {WIDTH{1'b0}});
   // A zero divisor leaves |a| in the remainder, so restoring the dividend's
   // sign reproduces the raw a operand for HI.
   assign quo_fix    = div_zero   ? {WIDTH{1'b1}} :
                       neg_result ? (~quo_raw + 1'b1) : quo_raw;
   assign rem_fix    = sign_a ? (~rem_raw + 1'b1) : rem_raw;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         is_div <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         a_abs  <= '0;
         b_abs  <= '0;
         sh     <= '0;
         acc    <= '0;
         hi_out <= '0;
         lo_out <= '0;
      end else if (ena) begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  is_div <= op_is_div(op);
                  sign_a <= start_signed & a[WIDTH-1];
                  sign_b <= start_signed & b[WIDTH-1];
                  a_abs  <= a_mag;
                  b_abs  <= b_mag;
                  sh     <= op_is_div(op) ? a_mag : b_mag;
                  acc    <= '0;
                  cnt    <= '0;
                  state  <= ST_CALC;
               end
            end
            ST_CALC: begin
               if (is_div) begin
                  acc <= div_next;
                  sh  <= {sh[WIDTH-2:0], 1'b0};
               end else begin
                  acc <= mul_next;
                  sh  <= {1'b0, sh[WIDTH-1:1]};
               end
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  state <= ST_FIX;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_FIX: begin
               if (is_div) begin
                  hi_out <= rem_fix;
                  lo_out <= quo_fix;
               end else begin
                  hi_out <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_out <= prod_fix[WIDTH-1:0];
               end
               state <= ST_DONE;
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);
   assign hi_w      = done & ena;
   assign lo_w      = done & ena;
   assign fsm_state = state;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
// Directed checks of mul_div_unit: reset state, each op, divide by zero,
// dropped and back-to-back starts, mid-operation reset and enable stalls.
// Cycle 0 is the cycle in which start is driven; cycle N is sampled
// shortly after the Nth following rising edge.
module tb_mul_div_unit;

   localparam logic [1:0] T_MULT  = 2'b00;
   localparam logic [1:0] T_MULTU = 2'b01;
   localparam logic [1:0] T_DIV   = 2'b10;
   localparam logic [1:0] T_DIVU  = 2'b11;

   logic        clk;
   logic        rst;
   logic        ena;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        hi_w;
   logic        lo_w;
   logic [1:0]  fsm_state;

   int checks;
   int failures;

   mul_div_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .hi_out    (hi_out),
      .lo_out    (lo_out),
      .hi_w      (hi_w),
      .lo_w      (lo_w),
      .fsm_state (fsm_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver ----------------
   // Launches op_i in cycle 0, optionally drives a second start (x_*) in
   // cycle x_cyc, holds ena low over [ena_lo, ena_hi], pulses rst in rst_cyc,
   // and runs a fixed number of cycles so it always terminates.
   task automatic run_op(
      input  logic [1:0]  op_i,
      input  logic [31:0] a_i,
      input  logic [31:0] b_i,
      input  int          x_cyc,
      input  logic [1:0]  x_op,
      input  logic [31:0] x_a,
      input  logic [31:0] x_b,
      input  int          ena_lo,
      input  int          ena_hi,
      input  int          rst_cyc,
      input  int          ncyc,
      output int          first_done,
      output int          n_done,
      output int          n_strobe,
      output int          strobe_cyc,
      output int          busy_cnt,
      output int          mask_err,
      output logic [1:0]  st33,
      output logic [31:0] hi_r,
      output logic [31:0] lo_r
   );
      first_done = -1;
      n_done     = 0;
      n_strobe   = 0;
      strobe_cyc = -1;
      busy_cnt   = 0;
      mask_err   = 0;
      st33       = 2'bxx;
      hi_r       = 32'hxxxx_xxxx;
      lo_r       = 32'hxxxx_xxxx;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      ena   = 1'b1;
      start = 1'b1;
      op    = op_i;
      a     = a_i;
      b     = b_i;
      for (int cyc = 1; cyc <= ncyc; cyc++) begin
         @(posedge clk);
         #1;
         ena   = !(cyc >= ena_lo && cyc <= ena_hi);
         rst   = (cyc == rst_cyc);
         start = (cyc == x_cyc);
         if (cyc == x_cyc) begin
            op = x_op;
            a  = x_a;
            b  = x_b;
         end else begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
         end
         #1;
         if (busy) busy_cnt++;
         if (done) begin
            if (first_done < 0) first_done = cyc;
            n_done++;
         end
         if (hi_w) begin
            n_strobe++;
            strobe_cyc = cyc;
            hi_r = hi_out;
            lo_r = lo_out;
         end
         if (hi_w !== (done & ena) || lo_w !== (done & ena)) mask_err++;
         if (cyc == 33) st33 = fsm_state;
      end
      start = 1'b0;
      rst   = 1'b0;
      ena   = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst   = 1'b1;
      ena   = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", busy); end
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b want=0", done); end
      checks++;
      if (hi_w !== 1'b0 || lo_w !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%0b%0b want=00", hi_w, lo_w); end
      checks++;
      if (hi_out !== 32'h0 || lo_out !== 32'h0) begin failures++; $display("FAIL reset_hilo got=%h_%h want=0_0", hi_out, lo_out); end
      checks++;
      if (fsm_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", fsm_state); end
   endtask

   task automatic test_multu();
      int fd, nd, ns, sc, bc, me;
      logic [1:0] s33;
      logic [31:0] h, l;
      run_op(T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 2'b00, 0, 0, -1, -1, -1, 50,
             fd, nd, ns, sc, bc, me, s33, h, l);
      checks++;
      if (h !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi got=%h want=fffffffe", h); end
      checks++;
      if (l !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo got=%h want=00000001", l); end
      checks++;
      if (fd !== 34) begin failures++; $display("FAIL multu_done_cycle got=%0d want=34", fd); end
      checks++;
      if (nd !== 1) begin failures++; $display("FAIL multu_done_count got=%0d want=1", nd); end
      checks++;
      if (ns !== 1 || sc !== 34) begin failures++; $display("FAIL multu_strobe got=%0d@%0d want=1@34", ns, sc); end
      checks++;
      if (bc !== 34) begin failures++; $display("FAIL multu_busy_cycles got=%0d want=34", bc); end
      checks++;
      if (s33 !== 2'd2) begin failures++; $display("FAIL multu_state_c33 got=%0d want=2", s33); end
      checks++;
      if (me !== 0) begin failures++; $display("FAIL multu_strobe_mask got=%0d want=0", me); end
   endtask

   task automatic test_mult();
      int fd, nd, ns, sc, bc, me;
      logic [1:0] s33;
      logic [31:0] h, l;
      run_op(T_MULT, 32'hFFFF_FFFD, 32'h0000_0007, -1, 2'b00, 0, 0, -1, -1, -1, 50,
             fd, nd, ns, sc, bc, me, s33, h, l);
      checks++;
      if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mult_neg got=%h_%h want=ffffffff_ffffffeb", h, l); end
      checks++;
      if (fd !== 34) begin failures++; $display("FAIL mult_neg_done got=%0d want=34", fd); end
      run_op(T_MULT, 32'h8000_0000, 32'h8000_0000, -1, 2'b00, 0, 0, -1, -1, -1, 50,
             fd, nd, ns, sc, bc, me, s33, h, l);
      checks++;
      if (h !== 32'h4000_0000 || l !== 32'h0) begin failures++; $display("FAIL mult_min got=%h_%h want=40000000_00000000", h, l); end
   endtask

   task automatic test_div();
      int fd, nd, ns, sc, bc, me;
      logic [1:0] s33;
      logic [31:0] h, l;
      run_op(T_DIV, 32'hFFFF_FFF9, 32'h0000_0002, -1, 2'b00, 0, 0, -1, -1, -1, 50,
             fd, nd, ns, sc, bc, me, s33, h, l);
      checks++;
      if (l !== 32'hFFFF_FFFD || h !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_neg got=hi %h lo %h want=hi ffffffff lo fffffffd", h, l); end
      checks++;
      if (fd !== 34) begin failures++; $display("FAIL div_done got=%0d want=34", fd); end
      run_op(T_DIVU, 32'h0000_0007, 32'h0000_0002, -1, 2'b00, 0, 0, -1, -1, -1, 50,
             fd, nd, ns, sc, bc, me, s33, h, l);
      checks++;
      if (l !== 32'h3 || h !== 32'h1) begin failures++; $display("FAIL divu got=hi %h lo %h want=hi 1 lo 3", h, l); end
      run_op(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, 2'b00, 0, 0, -1, -1, -1, 50,
             fd, nd, ns, sc, bc, me, s33, h, l);
      checks++;
      if (l !== 32'h8000_0000 || h !== 32'h0) begin failures++; $display("FAIL div_wrap got=hi %h lo %h want=hi 0 lo 80000000", h, l); end
   endtask

   task automatic test_div_zero();
      int fd, nd, ns, sc, bc, me;
      logic [1:0] s33;
      logic [31:0] h, l;
      run_op(T_DIVU, 32'h0000_0005, 32'h0, -1, 2'b00, 0, 0, -1, -1, -1, 50,
             fd, nd, ns, sc, bc, me, s33, h, l);
      checks++;
      if (h !== 32'h5 || l !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divu_zero got=hi %h lo %h want=hi 5 lo ffffffff", h, l); end
      checks++;
      if (fd !== 34) begin failures++; $display("FAIL divu_zero_done got=%0d want=34", fd); end
      run_op(T_DIV, 32'h0000_0005, 32'h0, -1, 2'b00, 0, 0, -1, -1, -1, 50,
             fd, nd, ns, sc, bc, me, s33, h, l);
      checks++;
      if (h !== 32'h5 || l !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_zero got=hi %h lo %h want=hi 5 lo ffffffff", h, l); end
      checks++;
      if (fd !== 34) begin failures++; $display("FAIL div_zero_done got=%0d want=34", fd); end
      run_op(T_DIV, 32'hFFFF_FFFB, 32'h0, -1, 2'b00, 0, 0, -1, -1, -1, 50,
             fd, nd, ns, sc, bc, me, s33, h, l);
      checks++;
      if (h !== 32'hFFFF_FFFB || l !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_zero_neg got=hi %h lo %h want=hi fffffffb lo ffffffff", h, l); end
   endtask

   task automatic test_dropped_start();
      int fd, nd, ns, sc, bc, me;
      logic [1:0] s33;
      logic [31:0] h, l;
      run_op(T_MULTU, 32'h3, 32'h4, 10, T_DIVU, 32'h7, 32'h2, -1, -1, -1, 50,
             fd, nd, ns, sc, bc, me, s33, h, l);
      checks++;
      if (h !== 32'h0 || l !== 32'hC) begin failures++; $display("FAIL drop_result got=%h_%h want=00000000_0000000c", h, l); end
      checks++;
      if (nd !== 1 || ns !== 1) begin failures++; $display("FAIL drop_pulses got=done %0d strobe %0d want=1 1", nd, ns); end
      checks++;
      if (fd !== 34) begin failures++; $display("FAIL drop_done got=%0d want=34", fd); end
   endtask

   task automatic test_back_to_back();
      int fd, nd, ns, sc, bc, me;
      logic [1:0] s33;
      logic [31:0] h, l;
      // Start in cycle 34 (still in DONE) must be dropped.
      run_op(T_MULTU, 32'h3, 32'h4, 34, T_DIVU, 32'h7, 32'h2, -1, -1, -1, 80,
             fd, nd, ns, sc, bc, me, s33, h, l);
      checks++;
      if (ns !== 1 || h !== 32'h0 || l !== 32'hC) begin failures++; $display("FAIL b2b_c34 got=strobes %0d %h_%h want=1 00000000_0000000c", ns, h, l); end
      checks++;
      if (bc !== 34) begin failures++; $display("FAIL b2b_c34_busy got=%0d want=34", bc); end
      // Start in cycle 35 is the earliest accepted one.
      run_op(T_MULTU, 32'h3, 32'h4, 35, T_DIVU, 32'h7, 32'h2, -1, -1, -1, 80,
             fd, nd, ns, sc, bc, me, s33, h, l);
      checks++;
      if (ns !== 2 || sc !== 69) begin failures++; $display("FAIL b2b_c35_strobe got=%0d@%0d want=2@69", ns, sc); end
      checks++;
      if (h !== 32'h1 || l !== 32'h3) begin failures++; $display("FAIL b2b_c35_result got=hi %h lo %h want=hi 1 lo 3", h, l); end
      checks++;
      if (bc !== 68) begin failures++; $display("FAIL b2b_c35_busy got=%0d want=68", bc); end
   endtask

   task automatic test_reset_mid();
      int fd, nd, ns, sc, bc, me;
      logic [1:0] s33;
      logic [31:0] h, l;
      run_op(T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 2'b00, 0, 0, -1, -1, 10, 50,
             fd, nd, ns, sc, bc, me, s33, h, l);
      checks++;
      if (bc !== 10) begin failures++; $display("FAIL rstmid_busy got=%0d want=10", bc); end
      checks++;
      if (nd !== 0 || ns !== 0) begin failures++; $display("FAIL rstmid_pulses got=done %0d strobe %0d want=0 0", nd, ns); end
      checks++;
      if (hi_out !== 32'h0 || lo_out !== 32'h0) begin failures++; $display("FAIL rstmid_hilo got=%h_%h want=0_0", hi_out, lo_out); end
   endtask

   task automatic test_ena();
      int fd, nd, ns, sc, bc, me;
      logic [1:0] s33;
      logic [31:0] h, l;
      run_op(T_MULT, 32'hFFFF_FFFD, 32'h7, -1, 2'b00, 0, 0, 20, 24, -1, 50,
             fd, nd, ns, sc, bc, me, s33, h, l);
      checks++;
      if (fd !== 39 || sc !== 39) begin failures++; $display("FAIL ena_calc_done got=%0d/%0d want=39/39", fd, sc); end
      checks++;
      if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFEB) begin failures++; $display("FAIL ena_calc_result got=%h_%h want=ffffffff_ffffffeb", h, l); end
      checks++;
      if (bc !== 39) begin failures++; $display("FAIL ena_calc_busy got=%0d want=39", bc); end
      // ena low across the DONE cycle: done held, strobe fires once when re-enabled.
      run_op(T_DIVU, 32'h7, 32'h2, -1, 2'b00, 0, 0, 34, 36, -1, 50,
             fd, nd, ns, sc, bc, me, s33, h, l);
      checks++;
      if (fd !== 34 || nd !== 4) begin failures++; $display("FAIL ena_done_hold got=first %0d count %0d want=34 4", fd, nd); end
      checks++;
      if (ns !== 1 || sc !== 37) begin failures++; $display("FAIL ena_done_strobe got=%0d@%0d want=1@37", ns, sc); end
      checks++;
      if (me !== 0) begin failures++; $display("FAIL ena_strobe_mask got=%0d want=0", me); end
      checks++;
      if (h !== 32'h1 || l !== 32'h3) begin failures++; $display("FAIL ena_done_result got=hi %h lo %h want=hi 1 lo 3", h, l); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_multu();
      test_mult();
      test_div();
      test_div_zero();
      test_dropped_start();
      test_back_to_back();
      test_reset_mid();
      test_ena();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

- Multi-cycle iterative multiply/divide unit that executes MULT, MULTU, DIV and DIVU.
- It is the producer side of the HI/LO register pair: it drives HI/LO write data and write strobes.
- The CPU launches an operation with a one-cycle `start`, stalls on `busy`, and sees the write land when `done` pulses.
- Radix-2: 32 iterations plus sign-fix, fixed latency for every op.

## Interface
- `WIDTH`, default 32: operand width. HI/LO are each `WIDTH` bits.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `ena`  in  1: block enable.
  - 0 freezes all state.
  - 0 combinationally forces `hi_w`/`lo_w` to 0.
- `start`  in  1: launch request, sampled only when `ena`=1 and `busy`=0.
- `op`  in  2: operation select.
  - 00 = MULT, 01 = MULTU, 10 = DIV, 11 = DIVU.
- `a`  in  WIDTH: rs operand (multiplicand or dividend), captured on accepted start.
- `b`  in  WIDTH: rt operand (multiplier or divisor), captured on accepted start.
- `busy`  out  1: operation in flight. New starts are ignored while high.
- `done`  out  1: one-cycle pulse; results valid in that cycle.
- `hi_out`  out  WIDTH: HI write data.
- `lo_out`  out  WIDTH: LO write data.
- `hi_w`  out  1: HI write strobe; equals `done & ena`.
- `lo_w`  out  1: LO write strobe; equals `done & ena`.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
  - IDLE→CALC on accepted start.
  - CALC→FIX when the iteration counter reaches 31.
  - FIX→DONE unconditionally.
  - DONE→IDLE unconditionally.
- **Accepted start:**
  - Latch the op.
  - Latch the sign flags (signed ops only).
  - Latch |a| and |b|. Unsigned ops use the raw values. Abs(0x80000000) = 0x80000000, treated as unsigned.
  - Clear the 64-bit accumulator and the counter.
- **Multiply (CALC):** shift-add, one multiplier bit per cycle, 64-bit unsigned product.
- **Divide (CALC):** restoring, one quotient bit per cycle; remainder and quotient are `WIDTH` bits each.
- **FIX, multiply:** negate the 64-bit product if sign(a) ≠ sign(b) for MULT.
  - HI = product[63:32], LO = product[31:0].
- **FIX, divide:**
  - Quotient is negated if the signs differ (DIV).
  - Remainder takes the sign of the dividend (DIV).
  - LO = quotient, HI = remainder.
- **Divide by zero:** HI = a (raw operand), LO = all ones, for both DIV and DIVU. Latency is the same as a normal divide.
- **DIV 0x80000000 / 0xFFFFFFFF:** LO = 0x80000000, HI = 0. This is the natural wrap; no trap.
- **Output register:** `hi_out`/`lo_out` are registered. They hold the last result until the next DONE.

## Timing
- **Reset:** `rst`=1 at a rising edge forces, on that edge:
  - state IDLE;
  - `busy`=0, `done`=0;
  - `hi_out`=0, `lo_out`=0;
  - counter 0.
- **Reset mid-operation:** aborts the operation with no write strobe. `rst` has priority over `ena` and `start`.
- **Latency:** with start accepted in cycle 0:
  - `busy`=1 in cycles 1–34;
  - CALC occupies cycles 1–32, FIX cycle 33;
  - `done`, `hi_w`, `lo_w` = 1 in cycle 34 only.
- **Back-to-back:** earliest next accepted start is cycle 35. Starts in cycles 0–34 other than the accepted one are dropped, with no queueing.
- **`ena`=0:** no state advances and no start is accepted.
  - If `ena`=0 during DONE, `done` stays registered high until `ena` returns.
  - The strobes stay masked while `ena`=0 and fire exactly one enabled cycle.
- **Operands:** `a`/`b` need to be stable only in the start cycle.

## Structure
- Package `mdu_pkg` contains:
  - op encoding constants OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - state enum (IDLE/CALC/FIX/DONE);
  - ITER_LAST = WIDTH-1.
- Sub-module `mdu_div_step`: combinational restoring step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new remainder and quotient bit.
- Control FSM, multiply datapath and sign fix stay in `mul_div_unit`.

## Test plan
- **MULTU:** 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
  - `done`/`hi_w`/`lo_w` high exactly in cycle 34.
- **MULT:** 0xFFFFFFFD (-3) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Also 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- **DIV:** -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/2 → LO=3, HI=1.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- **Divide by zero:** DIVU 5/0 and DIV 5/0 → HI=5, LO=0xFFFFFFFF, done in cycle 34.
- **Dropped start:** second start in cycle 10 of a MULTU 3×4 is ignored. Result HI=0, LO=12; one done pulse only.
- **Reset and `ena`:**
  - `rst` pulse in cycle 10 → `busy`=0 from cycle 11, no `hi_w`/`lo_w`, HI/LO outputs 0.
  - `ena`=0 for cycles 20–24 delays done to cycle 39.
